pmd901_speed_sched: RTL and testbench
=====================================

Name: pmd901_speed_sched

Overview:
Speed-command scheduler for the PMD901 SPI motor-driver path. It arbitrates signed speed setpoints from two requesters: a safety/supervisor channel and a host channel. It slews the committed speed toward the winning target at a bounded rate and emits one-cycle register writes (wdata/we) to the SPI block's speed register. It also sequences the driver enable (park) line around start/stop and handles fault/fan derating.

Parameters:
RAMP_STEP, 16'd64, maximum |speed change| per update tick
UPDATE_PERIOD, 20'd100000, clk cycles between update ticks (1 ms at 100 MHz); legal range 2..2^20-1
FAN_LIMIT, 16'd8192, magnitude clamp applied to the target while fan is high

Ports:
clk  in  1  system clock, 100 MHz; the only clock
rstn  in  1  synchronous reset, active-low
safe_valid  in  1  safety channel setpoint valid
safe_speed  in  16  safety setpoint, signed two's complement
safe_ready  out  1  safety setpoint accepted when valid&ready
host_valid  in  1  host channel setpoint valid
host_speed  in  16  host setpoint, signed
host_ready  out  1  host setpoint accepted when valid&ready
fault  in  1  PMD901 fault, active-high, level
fan  in  1  PMD901 near-overheat, active-high, level
wdata  out  16  speed value to SPI speed register
we  out  1  one-cycle write strobe
dev_enable  out  1  driver enable to SPI block
cur_speed  out  16  last committed (written) speed, signed
busy  out  1  high while cur_speed != target or state != PARKED/RUN-settled

Behaviour:
- Reset (rstn=0 at posedge): state=PARKED, target=0, cur_speed=0, wdata=0, we=0, dev_enable=0, tick counter=0, both readies=0. Reset mid-ramp aborts with no further we.
- Readies are combinational: safe_ready = !fault. host_ready = !fault & !safe_valid. Safe has fixed priority; on simultaneous valid, only safe is accepted that cycle.
- Accepted setpoint loads target on the next posedge. If fan=1, target is clamped to ±FAN_LIMIT, sign preserved. fan rising with an existing target over the limit re-clamps target on the next cycle.
- fault=1: target forced to 0 every cycle and nothing is accepted. Ramp-down proceeds at RAMP_STEP, not instantaneously.
- Tick: the counter counts 0..UPDATE_PERIOD-1 and wraps. The tick pulse fires at count==UPDATE_PERIOD-1. The counter free-runs in all states except reset.
- On tick, if cur_speed != target: diff = target - cur_speed, computed as 17-bit signed. step = min(RAMP_STEP, |diff|) with sign of diff. cur_speed, wdata <= cur_speed+step, and we=1 for exactly that cycle. If cur_speed == target, no we.
- Sign reversal ramps through 0 with no special stop; a write of 0 occurs only if a step lands exactly on 0.
- Target changes mid-ramp take effect at the next tick; there is no restart of the counter.
- State machine:
  - PARKED: dev_enable=0. Goes to RUN when target != 0; dev_enable=1 from the cycle of entry. First ramp write occurs at the next tick, never in the entry cycle.
  - RUN: dev_enable=1. Goes to STOPPING when target == 0.
  - STOPPING: dev_enable=1, ramping to 0. Returns to RUN if target becomes nonzero. Goes to PARKED in the cycle after the tick that writes cur_speed=0; dev_enable falls then.
- busy = (state!=PARKED) & (cur_speed!=target) | (state==STOPPING).
- Arithmetic: all speeds are 16-bit signed. Results never overflow, because the target is always within range and the step never exceeds |diff|.

Decomposition:
- Package pmd901_pkg: state enum (PARKED, RUN, STOPPING), speed_t (logic signed [15:0]), function clamp_mag(speed_t, limit), function ramp_step(cur, tgt, step).
- One sub-module pmd901_tick_gen: parameterised UPDATE_PERIOD counter producing the one-cycle tick; clk/rstn only.

Test Plan:
- Reset, then host setpoint 200 (UPDATE_PERIOD=10, RAMP_STEP=64) -> dev_enable rises next cycle; we writes 64, 128, 192, 200 on four consecutive ticks; then no we and busy=0.
- cur_speed=200, host setpoint -100 -> writes 136, 72, 8, -56, -100; state stays RUN; dev_enable held 1.
- safe_valid and host_valid in the same cycle (safe=50, host=300) -> safe_ready=1, host_ready=0; target=50; host held until the cycle after safe_valid drops.
- cur_speed=200 steady, fault asserted -> readies 0, writes 136, 72, 8, 0. PARKED the cycle after the 0 write; dev_enable=0.
- FAN_LIMIT=100, target 300, fan high -> target clamps to 100; ramp stops at 100. Host setpoint -500 while fan high -> ramps to -100.
- rstn low mid-ramp at cur_speed=128 -> next cycle all outputs 0 and no we until a new setpoint plus tick.

Source files
------------

// File: rtl/pmd901_pkg.sv
// Shared types and arithmetic helpers for the PMD901 speed scheduler.
package pmd901_pkg;

  typedef enum logic [1:0] {
    PARKED   = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  typedef logic signed [15:0] speed_t;

  // Clamp magnitude to limit, keeping the sign; limit must be positive.
  function automatic speed_t clamp_mag(input speed_t v, input speed_t limit);
    if (v > limit) return limit;
    if (v < -limit) return -limit;
    return v;
  endfunction

  // Move cur one bounded step toward tgt; 17-bit math so the difference never wraps.
  function automatic speed_t ramp_step(input speed_t cur, input speed_t tgt, input speed_t step);
    logic signed [16:0] diff;
    logic signed [16:0] mag;
    logic signed [16:0] lim;
    logic signed [16:0] stp;
    logic signed [16:0] nxt;
    diff = $signed({tgt[15], tgt}) - $signed({cur[15], cur});
    mag  = (diff < 0) ? -diff : diff;
    lim  = $signed({1'b0, step});
    stp  = (mag > lim) ? lim : mag;
    nxt  = (diff < 0) ? $signed({cur[15], cur}) - stp : $signed({cur[15], cur}) + stp;
    return speed_t'(nxt);
  endfunction

endpackage

// File: rtl/pmd901_tick_gen.sv
// Free-running update-period counter; tick is high for the last count of each period.
module pmd901_tick_gen #(
  parameter logic [19:0] UPDATE_PERIOD = 20'd100000
) (
  input  logic clk,
  input  logic rstn,
  output logic tick
);

  logic [19:0] count_reg;

  assign tick = (count_reg == UPDATE_PERIOD - 20'd1);

  always_ff @(posedge clk) begin
    if (!rstn)     count_reg <= '0;
    else if (tick) count_reg <= '0;
    else           count_reg <= count_reg + 20'd1;
  end

endmodule

// File: rtl/pmd901_speed_sched.sv
// Arbitrates safety/host speed setpoints, slews the committed speed at a bounded
// rate per tick, and sequences the driver enable around start/stop.
module pmd901_speed_sched
  import pmd901_pkg::*;
#(
  parameter logic [15:0] RAMP_STEP     = 16'd64,
  parameter logic [19:0] UPDATE_PERIOD = 20'd100000,
  parameter logic [15:0] FAN_LIMIT     = 16'd8192
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        safe_valid,
  input  logic [15:0] safe_speed,
  output logic        safe_ready,
  input  logic        host_valid,
  input  logic [15:0] host_speed,
  output logic        host_ready,
  input  logic        fault,
  input  logic        fan,
  output logic [15:0] wdata,
  output logic        we,
  output logic        dev_enable,
  output logic [15:0] cur_speed,
  output logic        busy
);

  state_t state_reg, state_next;
  speed_t target_reg, target_next;
  speed_t ramp_next;
  logic   tick;
  logic   at_target;

  pmd901_tick_gen #(.UPDATE_PERIOD(UPDATE_PERIOD)) u_tick (
    .clk  (clk),
    .rstn (rstn),
    .tick (tick)
  );

  // Safety channel has fixed priority; a fault blocks both channels.
  assign safe_ready = rstn & !fault;
  assign host_ready = rstn & !fault & !safe_valid;

  assign at_target  = (cur_speed == target_reg);
  assign ramp_next  = ramp_step(cur_speed, target_reg, RAMP_STEP);
  assign dev_enable = (state_reg != PARKED);
  assign busy       = ((state_reg != PARKED) & !at_target) | (state_reg == STOPPING);

  always_comb begin
    target_next = target_reg;
    if (fault)           target_next = '0;
    else if (safe_valid) target_next = fan ? clamp_mag(safe_speed, FAN_LIMIT) : safe_speed;
    else if (host_valid) target_next = fan ? clamp_mag(host_speed, FAN_LIMIT) : host_speed;
    else if (fan)        target_next = clamp_mag(target_reg, FAN_LIMIT);
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      PARKED:   if (target_reg != '0) state_next = RUN;
      RUN:      if (target_reg == '0) state_next = STOPPING;
      STOPPING: begin
        if (target_reg != '0)     state_next = RUN;
        else if (cur_speed == '0) state_next = PARKED;
      end
      default:  state_next = PARKED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) state_reg <= PARKED;
    else       state_reg <= state_next;
  end

  // Ramping is held off while parked so the first write lands on a tick after entry to RUN.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      target_reg <= '0;
      cur_speed  <= '0;
      wdata      <= '0;
      we         <= 1'b0;
    end else begin
      target_reg <= target_next;
      we         <= 1'b0;
      if (tick && (state_reg != PARKED) && !at_target) begin
        cur_speed <= ramp_next;
        wdata     <= ramp_next;
        we        <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pmd901_speed_sched.sv
// Randomized scoreboard bench: a behavioural model predicts each speed write, a monitor checks them.
module tb_pmd901_speed_sched;

  localparam int P    = 10;
  localparam int STEP = 64;
  localparam int FLIM = 100;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        safe_valid = 1'b0;
  logic [15:0] safe_speed = '0;
  logic        host_valid = 1'b0;
  logic [15:0] host_speed = '0;
  logic        fault = 1'b0;
  logic        fan = 1'b0;
  logic        safe_ready, host_ready, we, dev_enable, busy;
  logic [15:0] wdata, cur_speed;

  int compared = 0;
  int mismatched = 0;
  int exp_q[$];
  int m_cur = 0, m_tgt = 0, m_ph = 0, cyc = 0;

  always #5 clk = ~clk;

  pmd901_speed_sched #(
    .RAMP_STEP(16'd64), .UPDATE_PERIOD(20'd10), .FAN_LIMIT(16'd100)
  ) dut (
    .clk(clk), .rstn(rstn),
    .safe_valid(safe_valid), .safe_speed(safe_speed), .safe_ready(safe_ready),
    .host_valid(host_valid), .host_speed(host_speed), .host_ready(host_ready),
    .fault(fault), .fan(fan), .wdata(wdata), .we(we),
    .dev_enable(dev_enable), .cur_speed(cur_speed), .busy(busy)
  );

  function automatic int clampv(input int v);
    if (v > FLIM) return FLIM;
    if (v < -FLIM) return -FLIM;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phases 0=parked 1=run 2=stopping; one step per period toward target.
  initial begin
    int tgt_n, ph_n, s;
    bit tk;
    forever begin
      @(posedge clk);
      if (!rstn) begin
        m_cur = 0; m_tgt = 0; m_ph = 0; cyc = 0;
      end else begin
        tk = ((cyc % P) == P - 1);
        cyc++;
        tgt_n = m_tgt;
        if (fault)           tgt_n = 0;
        else if (safe_valid) tgt_n = fan ? clampv(int'($signed(safe_speed))) : int'($signed(safe_speed));
        else if (host_valid) tgt_n = fan ? clampv(int'($signed(host_speed))) : int'($signed(host_speed));
        else if (fan)        tgt_n = clampv(m_tgt);
        ph_n = m_ph;
        if (m_ph == 0)      begin if (m_tgt != 0) ph_n = 1; end
        else if (m_ph == 1) begin if (m_tgt == 0) ph_n = 2; end
        else begin
          if (m_tgt != 0) ph_n = 1;
          else if (m_cur == 0) ph_n = 0;
        end
        if (tk && m_ph != 0 && m_cur != m_tgt) begin
          s = m_tgt - m_cur;
          if (s > STEP) s = STEP;
          if (s < -STEP) s = -STEP;
          m_cur = m_cur + s;
          exp_q.push_back(m_cur);
        end
        m_tgt = tgt_n;
        m_ph  = ph_n;
      end
    end
  end

  // Monitor: pops an expected write whenever we is seen, and checks the status outputs each cycle.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (we) begin
        if (exp_q.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL unexpected_we: got wdata %0d expected no write (t=%0t)", $signed(wdata), $time);
        end else begin
          e = exp_q.pop_front();
          check("wdata", int'($signed(wdata)), e);
          $display("write %0d (expected %0d) t=%0t", $signed(wdata), e, $time);
        end
      end else if (exp_q.size() != 0) begin
        compared++; mismatched++;
        $display("FAIL missing_we: got no write expected wdata %0d (t=%0t)", exp_q[0], $time);
        exp_q.delete();
      end
      check("cur_speed", int'($signed(cur_speed)), m_cur);
      check("dev_enable", int'(dev_enable), int'(m_ph != 0));
      check("busy", int'(busy), int'((m_ph != 0 && m_cur != m_tgt) || m_ph == 2));
      check("safe_ready", int'(safe_ready), int'(rstn && !fault));
      check("host_ready", int'(host_ready), int'(rstn && !fault && !safe_valid));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_host(input int v);
    host_valid = 1'b1;
    host_speed = 16'(v);
    step(1);
    host_valid = 1'b0;
  endtask

  initial begin
    step(3);
    rstn = 1'b1;
    step(2);
    send_host(200);   step(60);
    send_host(-100);  step(70);
    // simultaneous requests: safe wins, host held one more cycle
    safe_valid = 1'b1; safe_speed = 16'd50;
    host_valid = 1'b1; host_speed = 16'd300;
    step(1);
    safe_valid = 1'b0;
    step(1);
    host_valid = 1'b0;
    step(100);
    send_host(200);   step(40);
    fault = 1'b1;     step(60);
    fault = 1'b0;     step(5);
    fan = 1'b1;
    send_host(300);   step(50);
    send_host(-500);  step(60);
    fan = 1'b0;
    send_host(300);   step(25);
    rstn = 1'b0;      step(2);
    rstn = 1'b1;      step(30);
    for (int i = 0; i < 3000; i++) begin
      safe_valid = ($urandom_range(0, 15) == 0);
      safe_speed = 16'(int'($urandom_range(0, 4000)) - 2000);
      host_valid = ($urandom_range(0, 7) == 0);
      host_speed = 16'(int'($urandom_range(0, 4000)) - 2000);
      if ($urandom_range(0, 199) == 0) fault = ~fault;
      if ($urandom_range(0, 99) == 0)  fan = ~fan;
      rstn = ($urandom_range(0, 499) != 0);
      step(1);
    end
    safe_valid = 1'b0; host_valid = 1'b0; fault = 1'b0; fan = 1'b0; rstn = 1'b1;
    step(700);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
